// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_pkg: shared constants, state encoding and flag helpers for the
// digit-serial multiplier sequencer (mul_seq_ctrl).
package mul_seq_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PROD_W      = 64;
  localparam int unsigned DIGIT_W_DEF = 4;
  localparam int unsigned ITER_DEF    = DATA_W / DIGIT_W_DEF;
  localparam int unsigned CNT_W_DEF   = $clog2(ITER_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the packed flag vector
  localparam int unsigned NUM_FLAGS = 10;
  localparam int unsigned FLAG_HSF  = 9;
  localparam int unsigned FLAG_HOF  = 8;
  localparam int unsigned FLAG_HCF  = 7;
  localparam int unsigned FLAG_HPF  = 6;
  localparam int unsigned FLAG_HZF  = 5;
  localparam int unsigned FLAG_LSF  = 4;
  localparam int unsigned FLAG_LOF  = 3;
  localparam int unsigned FLAG_LCF  = 2;
  localparam int unsigned FLAG_LPF  = 1;
  localparam int unsigned FLAG_LZF  = 0;

  // High/low word flags of a 64-bit product, same set as the parallel multiplier
  function automatic logic [NUM_FLAGS-1:0] calcFlags(input logic [PROD_W-1:0] r);
    logic [NUM_FLAGS-1:0] f;
    f           = '0;
    f[FLAG_HSF] = r[31];
    f[FLAG_HOF] = r[32] ^ r[31];
    f[FLAG_HCF] = r[32];
    f[FLAG_HPF] = r[0];
    f[FLAG_HZF] = (r[32:0] == 33'd0);
    f[FLAG_LSF] = r[32];
    f[FLAG_LOF] = r[63];
    f[FLAG_LCF] = 1'b0;
    f[FLAG_LPF] = r[32];
    f[FLAG_LZF] = (r == 64'd0);
    return f;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_pp.sv
// mul_seq_pp: combinational 32 x DIGIT_WIDTH partial product, built as a
// shift-add of the multiplicand under each digit bit.
module mul_seq_pp
  import mul_seq_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH = DIGIT_W_DEF
) (
  input  logic [DATA_W-1:0]             iSOURCE1,
  input  logic [DIGIT_WIDTH-1:0]        iDIGIT,
  output logic [DATA_W+DIGIT_WIDTH-1:0] oPP
);

  localparam int unsigned PP_W = DATA_W + DIGIT_WIDTH;

  // Sum the multiplicand shifted by every set digit bit
  always_comb begin
    oPP = '0;
    for (int i = 0; i < int'(DIGIT_WIDTH); i++) begin
      if (iDIGIT[i]) begin
        oPP = oPP + (PP_W'(iSOURCE1) << i);
      end
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle unsigned 32x32->64 multiplier sequencer.
// Folds one DIGIT_WIDTH-bit digit of iSOURCE0 per cycle into a 64-bit
// accumulator. Optional macro MUL_SEQ_CTRL_EARLY_TERM_EN stops as soon as the
// remaining multiplier digits are all zero.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH = DIGIT_W_DEF
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iFLUSH,
  input  logic              iREQ_VALID,
  output logic              oREQ_BUSY,
  input  logic [DATA_W-1:0] iSOURCE0,
  input  logic [DATA_W-1:0] iSOURCE1,
  output logic              oOUT_VALID,
  input  logic              iOUT_BUSY,
  output logic [PROD_W-1:0] oDATA,
  output logic              oHSF,
  output logic              oHOF,
  output logic              oHCF,
  output logic              oHPF,
  output logic              oHZF,
  output logic              oLSF,
  output logic              oLOF,
  output logic              oLCF,
  output logic              oLPF,
  output logic              oLZF
);

  localparam int unsigned ITER  = DATA_W / DIGIT_WIDTH;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam int unsigned PP_W  = DATA_W + DIGIT_WIDTH;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PROD_W-1:0]  acc;
  logic [DATA_W-1:0]  sReg;
  logic [DATA_W-1:0]  mReg;

  logic [PP_W-1:0]    pp;
  logic [5:0]         shAmt;
  logic [PROD_W-1:0]  accSum;
  logic [DATA_W-1:0]  sNext;
  logic               lastDigit;
  logic [NUM_FLAGS-1:0] flags;

  mul_seq_pp #(
    .DIGIT_WIDTH (DIGIT_WIDTH)
  ) uPp (
    .iSOURCE1 (mReg),
    .iDIGIT   (sReg[DIGIT_WIDTH-1:0]),
    .oPP      (pp)
  );

  // Accumulate the current digit's partial product at its weight
  always_comb begin
    shAmt  = 6'(cnt) * 6'(DIGIT_WIDTH);
    accSum = acc + (PROD_W'(pp) << shAmt);
    sNext  = sReg >> DIGIT_WIDTH;
`ifdef MUL_SEQ_CTRL_EARLY_TERM_EN
    lastDigit = (cnt == CNT_W'(ITER - 1)) || (sNext == '0);
`else
    lastDigit = (cnt == CNT_W'(ITER - 1));
`endif
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      sReg       <= '0;
      mReg       <= '0;
      oREQ_BUSY  <= 1'b0;
      oOUT_VALID <= 1'b0;
      oDATA      <= '0;
    end else if (iFLUSH) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      oREQ_BUSY  <= 1'b0;
      oOUT_VALID <= 1'b0;
      oDATA      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iREQ_VALID) begin
            sReg      <= iSOURCE0;
            mReg      <= iSOURCE1;
            acc       <= '0;
            cnt       <= '0;
            oREQ_BUSY <= 1'b1;
            state     <= CALC;
`ifdef MUL_SEQ_CTRL_EARLY_TERM_EN
            // Zero multiplier: product is already known to be zero
            if (iSOURCE0 == '0) begin
              state      <= DONE;
              oOUT_VALID <= 1'b1;
              oDATA      <= '0;
            end
`endif
          end
        end
        CALC: begin
          acc  <= accSum;
          sReg <= sNext;
          cnt  <= cnt + CNT_W'(1);
          if (lastDigit) begin
            state      <= DONE;
            oOUT_VALID <= 1'b1;
            oDATA      <= accSum;
          end
        end
        DONE: begin
          if (!iOUT_BUSY) begin
            state      <= IDLE;
            oOUT_VALID <= 1'b0;
            oREQ_BUSY  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          oOUT_VALID <= 1'b0;
          oREQ_BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Flags follow the presented result
  assign flags = calcFlags(oDATA);
  assign oHSF  = flags[FLAG_HSF];
  assign oHOF  = flags[FLAG_HOF];
  assign oHCF  = flags[FLAG_HCF];
  assign oHPF  = flags[FLAG_HPF];
  assign oHZF  = flags[FLAG_HZF];
  assign oLSF  = flags[FLAG_LSF];
  assign oLOF  = flags[FLAG_LOF];
  assign oLCF  = flags[FLAG_LCF];
  assign oLPF  = flags[FLAG_LPF];
  assign oLZF  = flags[FLAG_LZF];

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle unsigned 32x32->64 multiplier sequencer for the execute stage.
- Replaces the single-cycle parallel-adder multiplier where timing is critical.
- Each cycle it folds one DIGIT_WIDTH-bit digit of iSOURCE0 into a 64-bit accumulator using one shared 32xDIGIT partial-product unit.
- Valid/busy handshake on both sides; pipeline flush support; same flag set as the existing multiply path.

Parameters:
- DIGIT_WIDTH, 4: bits of iSOURCE0 consumed per cycle; must divide 32 (legal: 1, 2, 4, 8). ITER = 32/DIGIT_WIDTH.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  synchronous active-low reset
- iFLUSH  in  1  pipeline flush; abort any operation
- iREQ_VALID  in  1  operands valid
- oREQ_BUSY  out  1  cannot accept a request
- iSOURCE0  in  32  multiplier (digit-scanned)
- iSOURCE1  in  32  multiplicand
- oOUT_VALID  out  1  result valid
- iOUT_BUSY  in  1  consumer stall
- oDATA  out  64  product
- oHSF/oHOF/oHCF/oHPF/oHZF  out  1 each  high-word flags
- oLSF/oLOF/oLCF/oLPF/oLZF  out  1 each  low-word flags

Behaviour:
- Clock and reset: single clock iCLOCK. inRESET is synchronous, active-low.
- Reset values: state=IDLE, counter=0, accumulator=0, oREQ_BUSY=0, oOUT_VALID=0, oDATA=0; all flags derive from the zero result.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On iREQ_VALID & !iFLUSH: latch iSOURCE0 into shift register S and iSOURCE1 into M; acc=0, cnt=0; go to CALC.
  - Otherwise stay in IDLE.
- CALC, each cycle:
  - acc += (M * S[DIGIT_WIDTH-1:0]) << (cnt*DIGIT_WIDTH), computed at 64-bit width with no truncation.
  - S >>= DIGIT_WIDTH; cnt++.
  - When cnt==ITER-1, go to DONE.
- DONE: oOUT_VALID=1, oDATA=acc, held stable while iOUT_BUSY=1. When iOUT_BUSY=0 the result is consumed and the FSM goes to IDLE.
- Latency: request accepted at edge T -> oOUT_VALID high after edge T+ITER (8 cycles at default).
- Throughput: one operation per ITER+2 cycles minimum.
- oREQ_BUSY = (state != IDLE). A request in the cycle DONE hands off is not accepted; it is taken next cycle.
- iFLUSH (priority below reset, above all else):
  - Any state -> IDLE next edge; oOUT_VALID deasserts; result discarded.
  - A request coincident with iFLUSH is ignored.
- Flags, combinational from oDATA (r):
  - HSF=r[31], HOF=r[32]^r[31], HCF=r[32], HPF=r[0], HZF=(r[32:0]==0).
  - LSF=r[32], LOF=r[63], LCF=0, LPF=r[32], LZF=(r==0).
- Operands are unsigned; wrap-around cannot occur, since max 0xFFFFFFFF^2 = 0xFFFFFFFE00000001 fits in 64 bits.
- Zero operands are still processed (no special-casing) unless the optional feature below is compiled in.

Optional Feature:
- Macro: MUL_SEQ_CTRL_EARLY_TERM_EN.
- With the macro:
  - In CALC, if the post-shift S is zero, go to DONE at that edge, as well as at cnt==ITER-1.
  - On acceptance with iSOURCE0==0, go directly to DONE with acc=0 (latency 1).
  - Results and flags are bit-identical to the full run; only latency shortens.
- Without the macro: fixed latency ITER for all operands.

Decomposition:
- Package mul_seq_pkg:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - localparam-style constants for ITER and counter width ($clog2(ITER)).
  - flag bit-index constants.
- One sub-module: mul_seq_pp, combinational 32 x DIGIT_WIDTH -> (32+DIGIT_WIDTH) partial product built as a shift-add of iSOURCE1. This is the only arithmetic besides the 64-bit accumulate adder.

Test Plan:
- Reset/basic: inRESET low 2 cycles, release; request 0x00000003 x 0x00000005.
  - oREQ_BUSY high next cycle; oOUT_VALID exactly 8 cycles after accept.
  - oDATA=0x000000000000000F; HZF=0, LZF=0, HPF=1.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF -> oDATA=0xFFFFFFFE00000001; HCF=0, HSF=0, LOF=1, LCF=0.
- Backpressure: iOUT_BUSY=1 for 5 cycles at DONE with 0x10000 x 0x10000.
  - oDATA=0x0000000100000000 held stable; HZF=0, HCF=1, LZF=0.
  - Returns to IDLE the cycle after iOUT_BUSY drops; new request accepted the following cycle.
- Flush: assert iFLUSH at CALC cycle 4, with a new iREQ_VALID in the same cycle.
  - IDLE next edge; no oOUT_VALID pulse ever; the coincident request is not accepted.
  - A later request 7x6 yields 0x2A.
- Reset mid-operation: inRESET low in DONE with iOUT_BUSY=1 -> all outputs zero next edge, oREQ_BUSY=0.
- Early-term (macro defined): 0x0000000F x 0x12345678 -> oOUT_VALID 1 cycle after accept, oDATA=0x0000000111111108. 0 x anything -> DONE at accept edge, LZF=1. Without the macro the same operands take 8 cycles.
